// File: rtl/quad_adc_pkg.sv
// quad_adc_pkg: definitions shared by the quad ADC sample packer and its FIFO.
//   SAMPLE_W / EXT_W : raw ADC sample width and its sign-extended output width
//   ENTRY_W          : width of one buffered sample entry {CH4,CH3,CH2,CH1}
//   out_state_e      : output word sequencer states
//   sext16()         : sign-extends one 14-bit two's-complement sample to 16 bits
package quad_adc_pkg;

  localparam int SAMPLE_W = 14;
  localparam int EXT_W    = 16;
  localparam int ENTRY_W  = 4 * SAMPLE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WORD0 = 2'd1,
    ST_WORD1 = 2'd2
  } out_state_e;

  function automatic logic signed [EXT_W-1:0] sext16(input logic signed [SAMPLE_W-1:0] s);
    return {{(EXT_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous single-clock FIFO with a registered head-of-queue
// output. rdata_o always holds the oldest entry while the FIFO is non-empty,
// so the consumer can use it in the same cycle the entry becomes visible.
//   clk_i, rst_i : clock and synchronous active-high reset (pointers/count only)
//   push_i       : write wdata_i (ignored when full unless popping this cycle)
//   pop_i        : discard the head entry (ignored when empty)
//   rdata_o      : registered head entry
//   full_o, empty_o, count_o : occupancy status
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 56,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [AW:0]      count_q;
  logic [AW:0]      count_after_pop;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign rdata_o = rdata_q;

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Next head: a write into an (effectively) empty FIFO goes straight to the
  // head register; otherwise a pop exposes the following stored entry.
  always_comb begin
    rd_ptr_d        = rd_ptr_q + AW'(pop_ok);
    count_after_pop = count_q - (AW+1)'(pop_ok);
    rdata_d         = rdata_q;
    if (push_ok && (count_after_pop == '0)) begin
      rdata_d = wdata_i;
    end else if (pop_ok) begin
      rdata_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_after_pop + (AW+1)'(push_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
    rdata_q <= rdata_d;
  end

endmodule

// File: rtl/quad_sample_packer.sv
// quad_sample_packer: buffers 4-channel 14-bit ADC samples and emits each as
// two 32-bit words ({CH2,CH1} then {CH4,CH3}, each sign-extended to 16 bits)
// on a valid/ready stream, marking the last word of every PACKET_SAMPLES-sample
// packet. Samples that find the buffer full are dropped and counted.
//   AXI_CLK, RESET          : clock, synchronous active-high reset
//   ENABLE                  : capture enable, honoured only at packet boundaries
//   SAMPLE_VALID, CH_n_DATA : one-cycle sample strobe and the four channels
//   M_DATA/M_VALID/M_READY/M_LAST : output word stream
//   OVERFLOW, DROP_COUNT    : sticky drop flag and saturating drop count
//   CLEAR_OVERFLOW          : clears OVERFLOW and DROP_COUNT
module quad_sample_packer
  import quad_adc_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int PACKET_SAMPLES = 256
) (
  input  logic                AXI_CLK,
  input  logic                RESET,
  input  logic                ENABLE,
  input  logic                SAMPLE_VALID,
  input  logic [SAMPLE_W-1:0] CH_1_DATA,
  input  logic [SAMPLE_W-1:0] CH_2_DATA,
  input  logic [SAMPLE_W-1:0] CH_3_DATA,
  input  logic [SAMPLE_W-1:0] CH_4_DATA,
  output logic [31:0]         M_DATA,
  output logic                M_VALID,
  input  logic                M_READY,
  output logic                M_LAST,
  output logic                OVERFLOW,
  input  logic                CLEAR_OVERFLOW,
  output logic [15:0]         DROP_COUNT
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [15:0] PKT_LAST = 16'(PACKET_SAMPLES - 1);

  out_state_e         state_q;
  logic               m_valid_q;
  logic               m_last_q;
  logic [15:0]        pkt_cnt_q;
  logic               ovf_q;
  logic [15:0]        drop_cnt_q;

  logic [ENTRY_W-1:0] head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;

  logic               accept;
  logic               handshake;
  logic               pop;
  logic               push;
  logic               drop;
  logic               more_after_pop;

  // Capture: mid-packet samples are always taken so a packet is never cut
  // short by ENABLE falling.
  assign accept         = SAMPLE_VALID && !RESET && (ENABLE || (pkt_cnt_q != '0));
  assign handshake      = m_valid_q && M_READY;
  assign pop            = handshake && (state_q == ST_WORD1);
  assign push           = accept && (!fifo_full || pop);
  assign drop           = accept && fifo_full && !pop;
  // A push landing in the same cycle as the last pop keeps the stream going.
  assign more_after_pop = (fifo_count > CNT_ONE) || push;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (AXI_CLK),
    .rst_i   (RESET),
    .push_i  (push),
    .wdata_i ({CH_4_DATA, CH_3_DATA, CH_2_DATA, CH_1_DATA}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Output sequencer: two words per buffered entry.
  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q   <= ST_WORD0;
            m_valid_q <= 1'b1;
          end
        end
        ST_WORD0: begin
          if (M_READY) begin
            state_q  <= ST_WORD1;
            m_last_q <= (pkt_cnt_q == PKT_LAST);
          end
        end
        ST_WORD1: begin
          if (M_READY) begin
            m_last_q <= 1'b0;
            if (more_after_pop) begin
              state_q <= ST_WORD0;
            end else begin
              state_q   <= ST_IDLE;
              m_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
        end
      endcase
    end
  end

  // Word data comes from the registered FIFO head, which only changes on a pop.
  always_comb begin
    case (state_q)
      ST_WORD0: M_DATA = {sext16(head[1*SAMPLE_W +: SAMPLE_W]), sext16(head[0*SAMPLE_W +: SAMPLE_W])};
      ST_WORD1: M_DATA = {sext16(head[3*SAMPLE_W +: SAMPLE_W]), sext16(head[2*SAMPLE_W +: SAMPLE_W])};
      default:  M_DATA = '0;
    endcase
  end

  assign M_VALID = m_valid_q;
  assign M_LAST  = m_last_q;

  // Packet position: index within the packet of the entry currently at the head.
  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      pkt_cnt_q <= '0;
    end else if (pop) begin
      pkt_cnt_q <= (pkt_cnt_q == PKT_LAST) ? 16'd0 : pkt_cnt_q + 16'd1;
    end
  end

  // Drop accounting: a drop wins over a simultaneous clear.
  always_ff @(posedge AXI_CLK) begin
    if (RESET) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (CLEAR_OVERFLOW) begin
        drop_cnt_q <= 16'd1;
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end else if (CLEAR_OVERFLOW) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  assign OVERFLOW   = ovf_q;
  assign DROP_COUNT = drop_cnt_q;

endmodule

// File: tb/tb_quad_sample_packer.sv
// Bench for quad_sample_packer (FIFO_DEPTH=4, PACKET_SAMPLES=4): directed
// scenarios with literal expectations plus a randomized run, all shadowed by a
// queue-based model that is checked on every falling clock edge.
module tb_quad_sample_packer;

  localparam int DEPTH = 4;
  localparam int P     = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic        sv;
  logic [13:0] c1, c2, c3, c4;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        ovf;
  logic        clr;
  logic [15:0] drop_cnt;

  quad_sample_packer #(
    .FIFO_DEPTH     (DEPTH),
    .PACKET_SAMPLES (P)
  ) dut (
    .AXI_CLK        (clk),
    .RESET          (rst),
    .ENABLE         (en),
    .SAMPLE_VALID   (sv),
    .CH_1_DATA      (c1),
    .CH_2_DATA      (c2),
    .CH_3_DATA      (c3),
    .CH_4_DATA      (c4),
    .M_DATA         (m_data),
    .M_VALID        (m_valid),
    .M_READY        (m_ready),
    .M_LAST         (m_last),
    .OVERFLOW       (ovf),
    .CLEAR_OVERFLOW (clr),
    .DROP_COUNT     (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Model state: queued entries, which half of the head is on the bus,
  // samples already emitted in the current packet, drop bookkeeping.
  logic [55:0] mq[$];
  bit          wsel;
  int          pcnt;
  bit          movf;
  int          mdrop;
  bit          ne_prev;
  logic        pv_valid, pv_ready, pv_last;
  logic [31:0] pv_data;
  int          words;
  int          last_pos[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sx(input logic [13:0] s);
    int v;
    v = int'(s);
    if (v >= 8192) v = v - 16384;
    return 16'(v);
  endfunction

  function automatic logic [31:0] word_of(input logic [55:0] e, input bit hi);
    if (hi) return {sx(e[55:42]), sx(e[41:28])};
    return {sx(e[27:14]), sx(e[13:0])};
  endfunction

  // Check the current outputs against the model, then advance the model over
  // the coming rising edge using the inputs that edge will sample.
  task automatic model_eval();
    bit ne_now, ev, hs, pop, acc, pok;
    ne_now = (mq.size() != 0);
    ev     = ne_now && ne_prev;
    chk("m_valid", 32'(m_valid), 32'(ev));
    chk("overflow", 32'(ovf), 32'(movf));
    chk("drop_count", 32'(drop_cnt), 32'(mdrop));
    if (ev) begin
      chk("m_data", m_data, word_of(mq[0], wsel));
      chk("m_last", 32'(m_last), 32'(wsel && (pcnt == P-1)));
    end
    if (pv_valid && !pv_ready && m_valid) begin
      chk("hold_data", m_data, pv_data);
      chk("hold_last", 32'(m_last), 32'(pv_last));
    end
    pv_valid = m_valid; pv_ready = m_ready; pv_data = m_data; pv_last = m_last;
    if (m_valid && m_ready) begin
      words++;
      if (m_last) last_pos.push_back(words);
    end
    if (rst) begin
      mq.delete(); wsel = 0; pcnt = 0; movf = 0; mdrop = 0; ne_prev = 0;
    end else begin
      hs  = ev && m_ready;
      pop = hs && wsel;
      acc = sv && (en || (pcnt != 0));
      pok = acc && ((mq.size() < DEPTH) || pop);
      if (acc && !pok) begin
        movf  = 1;
        mdrop = clr ? 1 : ((mdrop < 65535) ? mdrop + 1 : mdrop);
      end else if (clr) begin
        movf = 0; mdrop = 0;
      end
      if (pop) begin
        void'(mq.pop_front());
        pcnt = (pcnt + 1) % P;
      end
      if (hs) wsel = !wsel;
      if (pok) mq.push_back({c4, c3, c2, c1});
      ne_prev = ne_now;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [13:0] a, input logic [13:0] b,
                        input logic [13:0] c, input logic [13:0] d);
    c1 = a; c2 = b; c3 = c; c4 = d;
    sv = 1'b1;
    step();
    sv = 1'b0;
  endtask

  task automatic strobe_rand();
    strobe(14'($urandom), 14'($urandom), 14'($urandom), 14'($urandom));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Every 8th word since bw must carry M_LAST, and no other word.
  task automatic check_packet(input string tag, input int bw, input int bl, input int nwords);
    chk({tag, "_words"}, 32'(words - bw), 32'(nwords));
    chk({tag, "_nlast"}, 32'(last_pos.size() - bl), 32'(nwords / 8));
    for (int i = 0; i < nwords / 8; i++) begin
      if (bl + i < last_pos.size())
        chk({tag, "_lastpos"}, 32'(last_pos[bl + i] - bw), 32'(8 * (i + 1)));
    end
  endtask

  initial begin
    int bw, bl, n;
    total = 0; bad = 0;
    rst = 1'b1; en = 1'b0; sv = 1'b0; m_ready = 1'b0; clr = 1'b0;
    c1 = '0; c2 = '0; c3 = '0; c4 = '0;
    wsel = 0; pcnt = 0; movf = 0; mdrop = 0; ne_prev = 0; words = 0;
    pv_valid = 0; pv_ready = 0; pv_data = '0; pv_last = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;

    // Single sample: word order, sign extension and two-cycle latency.
    en = 1'b1; m_ready = 1'b1;
    step();
    strobe(14'h1FFF, 14'h2000, 14'h0001, 14'h3FFF);
    chk("lat_n1_valid", 32'(m_valid), 32'd0);
    step();
    chk("lat_n2_valid", 32'(m_valid), 32'd1);
    chk("word0", m_data, 32'hE0001FFF);
    step();
    chk("word1", m_data, 32'hFFFF0001);
    chk("word1_last", 32'(m_last), 32'd0);
    step();
    chk("idle_after", 32'(m_valid), 32'd0);

    // Two packets of 4 samples: M_LAST on words 8 and 16 only.
    do_reset();
    bw = words; bl = last_pos.size();
    for (int i = 0; i < 8; i++) begin
      strobe_rand();
      step();
    end
    repeat (10) step();
    check_packet("pkt2", bw, bl, 16);

    // Overflow with a stalled sink, clear priority, then full-rate drain.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) strobe_rand();
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("drop_two", 32'(drop_cnt), 32'd2);
    clr = 1'b1;
    strobe_rand();
    clr = 1'b0;
    chk("drop_vs_clr_ovf", 32'(ovf), 32'd1);
    chk("drop_vs_clr_cnt", 32'(drop_cnt), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", 32'(ovf), 32'd0);
    chk("clr_cnt", 32'(drop_cnt), 32'd0);
    bw = words;
    m_ready = 1'b1;
    repeat (8) step();
    chk("thruput_words", 32'(words - bw), 32'd8);
    repeat (4) step();
    chk("drain_words", 32'(words - bw), 32'd8);
    chk("drain_idle", 32'(m_valid), 32'd0);

    // ENABLE falls mid-packet: the packet still completes, the next is held off.
    do_reset();
    bw = words; bl = last_pos.size();
    en = 1'b1;
    strobe_rand(); repeat (5) step();
    strobe_rand(); repeat (5) step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      strobe_rand();
      repeat (5) step();
    end
    check_packet("en_gate", bw, bl, 8);
    en = 1'b1;

    // Reset while in the second word with 3 entries queued.
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) strobe_rand();
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("pre_rst_valid", 32'(m_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_data", m_data, 32'd0);
    chk("abort_last", 32'(m_last), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_empty", 32'(m_valid), 32'd0);
    end
    m_ready = 1'b1;
    bw = words; bl = last_pos.size();
    for (int i = 0; i < 4; i++) begin
      strobe_rand();
      step();
    end
    repeat (8) step();
    check_packet("post_rst", bw, bl, 8);

    // Randomized traffic with a stalling sink.
    do_reset();
    n = 0;
    for (int cyc = 0; cyc < 3000 && n < 100; cyc++) begin
      sv = ($urandom_range(0, 2) == 0);
      if (sv) n++;
      c1 = 14'($urandom); c2 = 14'($urandom); c3 = 14'($urandom); c4 = 14'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      en      = ($urandom_range(0, 7) != 0);
      clr     = ($urandom_range(0, 15) == 0);
      step();
    end
    sv = 1'b0; clr = 1'b0; en = 1'b1; m_ready = 1'b1;
    repeat (20) step();
    chk("rand_strobes", 32'(n), 32'd100);
    chk("rand_drained", 32'(m_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
